// File: rtl/reg_file_sb_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned XLEN_DEF = 32'd32;
  localparam int unsigned NBYTES   = XLEN_DEF / 32'd8;

  // Widest datapath the merge helper supports; callers widen/truncate around it.
  localparam int unsigned MAX_XLEN = 32'd256;
  localparam int unsigned MAX_NB   = MAX_XLEN / 32'd8;

  function automatic logic [MAX_XLEN-1:0] byte_merge(
    input logic [MAX_XLEN-1:0] old_v,
    input logic [MAX_XLEN-1:0] new_v,
    input logic [MAX_NB-1:0]   be
  );
    logic [MAX_XLEN-1:0] res;
    res = old_v;
    for (int k = 0; k < int'(MAX_NB); k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback side bus of the register file.
interface reg_file_sb_if #(
  parameter int unsigned XLEN   = 32'd32,
  parameter int unsigned ADDR_W = 32'd5,
  parameter int unsigned NREAD  = 32'd2
);
  logic                    busy;
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*XLEN-1:0]   rd;
  logic [NREAD-1:0]        rpend;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [XLEN-1:0]         wd;
  logic [XLEN/8-1:0]       wbe;
  logic                    pset;
  logic [ADDR_W-1:0]       paddr;

  modport master (
    output ra, we, wa, wd, wbe, pset, paddr,
    input  rd, rpend, busy
  );

  modport slave (
    input  ra, we, wa, wd, wbe, pset, paddr,
    output rd, rpend, busy
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, set wins on collision.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32'd5,
  parameter int unsigned NREAD    = 32'd2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    set,
  input  logic [ADDR_W-1:0]       set_addr,
  input  logic                    clr,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD-1:0]        rpend
);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_next_s;
  logic             set_ok_s;

  assign set_ok_s = set && !(ZERO_REG && (set_addr == ZERO_ADDR));

  // next pending vector with set-over-clear priority
  always_comb begin
    pend_next_s = pend_r;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (!en) begin
        pend_next_s[j] = pend_r[j];
      end else if (set_ok_s && (set_addr == ADDR_W'(j))) begin
        pend_next_s[j] = 1'b1;
      end else if (clr && (clr_addr == ADDR_W'(j))) begin
        pend_next_s[j] = 1'b0;
      end else begin
        pend_next_s[j] = pend_r[j];
      end
    end
  end

  // pending state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_next_s;
    end
  end

  // lookup ports show stored state only
  always_comb begin
    rpend = {NREAD{1'b0}};
    for (int i = 0; i < int'(NREAD); i++) begin
      rpend[i] = pend_r[ra[i*ADDR_W +: ADDR_W]];
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with byte enables, write bypass,
// hardware clear after reset and a pending scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32'd32,
  parameter int unsigned ADDR_W   = 32'd5,
  parameter int unsigned NREAD    = 32'd2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam int unsigned NB    = XLEN / 32'd8;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

  function automatic logic [XLEN-1:0] merge_w(
    input logic [XLEN-1:0] old_v,
    input logic [XLEN-1:0] new_v,
    input logic [NB-1:0]   be
  );
    return XLEN'(byte_merge(MAX_XLEN'(old_v), MAX_XLEN'(new_v), MAX_NB'(be)));
  endfunction

  rf_state_e         state_r, state_next_s;
  logic [ADDR_W-1:0] idx_r, idx_next_s;
  logic              clr_en_s;
  logic              busy_s;
  logic              wr_en_s;
  logic [XLEN-1:0]   wr_data_s;
  logic [NREAD-1:0]  sb_rpend_s;
  logic [XLEN-1:0]   mem_r [DEPTH];

  // FSM state and clear index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      idx_r   <= ZERO_ADDR;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // next state: CLEAR walks every entry once, then RUN until reset
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    clr_en_s     = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_en_s   = 1'b1;
        idx_next_s = idx_r + ADDR_W'(1);
        if (idx_r == IDX_LAST) begin
          state_next_s = RUN;
        end else begin
          state_next_s = CLEAR;
        end
      end
      RUN: begin
        state_next_s = RUN;
      end
      default: begin
        state_next_s = CLEAR;
        idx_next_s   = ZERO_ADDR;
      end
    endcase
  end

  assign busy_s    = (state_r == CLEAR);
  assign bus.busy  = busy_s;
  assign wr_en_s   = !rst && !busy_s && bus.we && !(ZERO_REG && (bus.wa == ZERO_ADDR));
  assign wr_data_s = merge_w(mem_r[bus.wa], bus.wd, bus.wbe);

  // storage update: clear sweep or byte-enabled writeback
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      mem_r[idx_r] <= {XLEN{1'b0}};
    end else if (wr_en_s) begin
      mem_r[bus.wa] <= wr_data_s;
    end
  end

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [XLEN-1:0]   rd_s;

    assign ra_s = bus.ra[i*ADDR_W +: ADDR_W];

    // read mux: forced zero, same-cycle bypass, or stored entry
    always_comb begin
      rd_s = mem_r[ra_s];
      if (busy_s || (ZERO_REG && (ra_s == ZERO_ADDR))) begin
        rd_s = {XLEN{1'b0}};
      end else if (BYPASS && wr_en_s && (bus.wa == ra_s)) begin
        rd_s = wr_data_s;
      end else begin
        rd_s = mem_r[ra_s];
      end
    end

    assign bus.rd[i*XLEN +: XLEN] = rd_s;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (!busy_s),
    .set      (bus.pset),
    .set_addr (bus.paddr),
    .clr      (bus.we),
    .clr_addr (bus.wa),
    .ra       (bus.ra),
    .rpend    (sb_rpend_s)
  );

  assign bus.rpend = sb_rpend_s & ~{NREAD{busy_s}};
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: one bypassing and one non-bypassing register file on shared stimulus.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  reg_file_sb_if bus0 ();
  reg_file_sb_if bus1 ();

  assign bus1.ra    = bus0.ra;
  assign bus1.we    = bus0.we;
  assign bus1.wa    = bus0.wa;
  assign bus1.wd    = bus0.wd;
  assign bus1.wbe   = bus0.wbe;
  assign bus1.pset  = bus0.pset;
  assign bus1.paddr = bus0.paddr;

  reg_file_sb #(.XLEN(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_byp (.clk(clk), .rst(rst), .bus(bus0));

  reg_file_sb #(.XLEN(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_nobyp (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.we    = 1'b0;
    bus0.wa    = 5'd0;
    bus0.wd    = 32'h0;
    bus0.wbe   = 4'b0000;
    bus0.pset  = 1'b0;
    bus0.paddr = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus0.ra = 10'd0;
    tick();
    rst = 1'b0;
    #1;
    check("reset_busy", bus0.busy, 64'd1);
    check("reset_rd", bus0.rd, 64'd0);
    check("reset_rpend", bus0.rpend, 64'd0);

    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("clear_busy_cycles", n, 64'd32);
    check("clear_busy_nobyp", bus1.busy, 64'd0);

    for (int a = 0; a < 32; a++) begin
      bus0.ra = {5'(31 - a), 5'(a)};
      #1;
      check("clear_rd_byp", bus0.rd, 64'd0);
      check("clear_rd_nobyp", bus1.rd, 64'd0);
    end

    // byte enables
    bus0.we = 1'b1; bus0.wa = 5'd5; bus0.wd = 32'hAABBCCDD; bus0.wbe = 4'b1111;
    tick();
    bus0.wd = 32'h11223344; bus0.wbe = 4'b0101;
    tick();
    idle();
    bus0.ra = {5'd0, 5'd5};
    #1;
    check("wbe_merge_byp", bus0.rd[31:0], 64'hAA22CC44);
    check("wbe_merge_nobyp", bus1.rd[31:0], 64'hAA22CC44);

    // same-cycle bypass
    bus0.ra = {5'd7, 5'd7};
    bus0.we = 1'b1; bus0.wa = 5'd7; bus0.wd = 32'hDEADBEEF; bus0.wbe = 4'b0011;
    #1;
    check("bypass_on", bus0.rd, {2{32'h0000BEEF}});
    check("bypass_off", bus1.rd, 64'd0);
    tick();
    idle();
    #1;
    check("bypass_off_next", bus1.rd, {2{32'h0000BEEF}});
    check("bypass_on_next", bus0.rd, {2{32'h0000BEEF}});

    // zero register
    bus0.ra = 10'd0;
    bus0.we = 1'b1; bus0.wa = 5'd0; bus0.wd = 32'hFFFFFFFF; bus0.wbe = 4'b1111;
    bus0.pset = 1'b1; bus0.paddr = 5'd0;
    #1;
    check("zero_rd_same", bus0.rd, 64'd0);
    tick();
    idle();
    #1;
    check("zero_rd_byp", bus0.rd, 64'd0);
    check("zero_rd_nobyp", bus1.rd, 64'd0);
    check("zero_rpend", bus0.rpend, 64'd0);

    // scoreboard priority
    bus0.ra = {5'd3, 5'd3};
    bus0.pset = 1'b1; bus0.paddr = 5'd3;
    #1;
    check("sb_before_set", bus0.rpend, 64'd0);
    tick();
    idle();
    #1;
    check("sb_set", bus0.rpend, 64'd3);
    bus0.we = 1'b1; bus0.wa = 5'd3; bus0.wd = 32'h12345678; bus0.wbe = 4'b0000;
    bus0.pset = 1'b1; bus0.paddr = 5'd3;
    tick();
    idle();
    #1;
    check("sb_set_wins", bus0.rpend, 64'd3);
    check("sb_wbe0_nodata", bus1.rd, 64'd0);
    bus0.we = 1'b1; bus0.wa = 5'd3; bus0.wbe = 4'b0000;
    #1;
    check("sb_no_clr_bypass", bus0.rpend, 64'd3);
    tick();
    idle();
    #1;
    check("sb_clr", bus0.rpend, 64'd0);
    check("sb_clr_nobyp", bus1.rpend, 64'd0);

    // mid-clear reset and dropped operations
    bus0.ra = {5'd5, 5'd2};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 10) begin
        bus0.we = 1'b1; bus0.wa = 5'd2; bus0.wd = 32'hFFFFFFFF; bus0.wbe = 4'b1111;
        bus0.pset = 1'b1; bus0.paddr = 5'd2;
        #1;
        check("midclr_busy", bus0.busy, 64'd1);
        check("midclr_rd", bus0.rd, 64'd0);
      end
      if (c == 11) idle();
      if (c == 12) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      n++;
      if (n == 20) begin
        bus0.we = 1'b1; bus0.wa = 5'd3; bus0.wd = 32'hFFFFFFFF; bus0.wbe = 4'b1111;
        bus0.pset = 1'b1; bus0.paddr = 5'd5;
      end
      if (n == 21) idle();
      tick();
    end
    check("reclear_busy_cycles", n, 64'd32);
    #1;
    check("reclear_rd_2_5", bus0.rd, 64'd0);
    check("reclear_rpend_2_5", bus0.rpend, 64'd0);
    bus0.ra = {5'd5, 5'd3};
    #1;
    check("drop_we_rd", bus0.rd, 64'd0);
    check("drop_pset_rpend", bus0.rpend, 64'd0);
    check("drop_we_rd_nobyp", bus1.rd, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's integer register file.
- Configurable width, depth and read-port count; per-byte write enables; optional write-to-read bypass; a per-register pending scoreboard for in-flight producers.
- After reset, a hardware clear sequence zeroes every entry.
- Sits between decode (read and scoreboard) and writeback (write) in the pipelined CPU.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads see stored value only.
- ZERO_REG, 1, 1 = entry 0 is hard-wired to zero (never written, never pending).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear sequence runs.
- ra  in  NREAD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd  out  NREAD*XLEN  read data, combinational from ra; port i uses bits [i*XLEN +: XLEN].
- rpend  out  NREAD  bit i = scoreboard pending bit of ra[i], combinational.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  XLEN  write data.
- wbe  in  XLEN/8  byte enables; bit k covers wd[8k+7:8k].
- pset  in  1  mark pending: an instruction targeting paddr has issued.
- paddr  in  ADDR_W  scoreboard set address.

Behaviour:
- Reset: on rising edge with rst=1:
  - FSM enters CLEAR with clear index = 0; busy=1 from the next cycle.
  - All pending bits cleared.
  - rd reads 0 and rpend reads 0 while busy.
  - rst asserted mid-CLEAR restarts the index at 0.
- FSM states:
  - CLEAR: each cycle writes 0 to entry[index], index++. At index = DEPTH-1 the FSM moves to RUN on the following edge. Exactly DEPTH cycles; busy falls in the cycle the FSM enters RUN.
  - RUN: normal operation; stays until rst.
  - Power-up without reset is undefined; the bench always applies rst.
- Writes (RUN only):
  - On edge with we=1, byte k of entry[wa] is updated from wd when wbe[k]=1; other bytes hold. wbe=0 is a no-op.
  - we during CLEAR is dropped silently.
- Reads:
  - Combinational, zero latency.
  - rd[i] = 0 if busy, or if ZERO_REG=1 and ra[i]=0.
  - Otherwise, if BYPASS=1, we=1 and wa=ra[i], rd[i] = byte-merge of wd (enabled bytes) and stored entry (disabled bytes).
  - Otherwise rd[i] = stored entry.
  - Multiple ports reading the same address all get identical data.
- Scoreboard (RUN only):
  - pset=1 sets pending[paddr] on the edge.
  - we=1 (any wbe, including 0) clears pending[wa] on the edge.
  - Same edge, same address for pset and we: set wins, pending stays 1 (newer producer issued).
  - ZERO_REG=1: pending[0] is never set.
  - pset during CLEAR is dropped.
  - rpend[i] reflects stored pending state; there is no bypass of the same-cycle clear.
- ZERO_REG=1: we to address 0 changes nothing, neither storage nor scoreboard.
- Width rules:
  - Addresses are unsigned.
  - Index counter is ADDR_W bits; termination uses the all-ones compare, not overflow.

Decomposition:
- Shared package (regfile_pkg):
  - FSM state enum {CLEAR, RUN}.
  - Constant NBYTES = XLEN/8.
  - Function for byte-merge(old, new, be), used by both the write and bypass paths.
- One natural sub-module: rf_scoreboard, holding the DEPTH-bit pending vector with set/clear priority and NREAD lookup ports. Storage, the clear FSM and the bypass stay in the top.

Test Plan:
- Clear: assert rst 1 cycle with defaults. busy=1 for exactly 32 cycles, then 0. Read all 32 entries on both ports: all return 0x00000000.
- Byte enables: write 0xAABBCCDD to r5 with wbe=4'b1111, then 0x11223344 with wbe=4'b0101. rd of r5 = 0xAA22CC44.
- Bypass:
  - BYPASS=1: r7 holds 0x0; same cycle we=1, wa=7, wd=0xDEADBEEF, wbe=4'b0011, ra[0]=7 → rd[0]=0x0000BEEF combinationally.
  - BYPASS=0: rd[0]=0x0 until the next cycle.
- Zero register: write 0xFFFFFFFF to r0 and pset to r0. rd=0 and rpend=0 on all ports.
- Scoreboard priority:
  - pset r3 → rpend=1 next cycle.
  - Later, same edge we to r3 with pset to r3 → r3 stays pending.
  - Next we to r3 alone → rpend=0.
- Mid-clear reset and dropped ops: after rst, at cycle 10 of CLEAR issue we to r2 and pset to r2, then reassert rst at cycle 12. busy stays high for 32 more cycles; afterwards r2 reads 0 and rpend for r2 = 0.
